// File: rtl/bus_ram_responder.sv
// Purpose: word-addressed RAM target for the pCPU a/d/we/rd/spo/ready bus, one aligned window.
// Latency: LATENCY wait states (0 = combinational read, same-cycle ready).
// Backpressure: ready drops while a transaction is outstanding; requests seen while busy are dropped and flagged in err.
module bus_ram_responder #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter logic [31:0] BASE_ADDR  = 32'hf0000000,
   parameter int unsigned LATENCY    = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] a,
   input  logic [31:0] d,
   input  logic        we,
   input  logic        rd,
   output logic [31:0] spo,
   output logic        ready,
   output logic        err
);

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_BUSY = 1'b1;
   localparam int unsigned DEPTH  = 1 << ADDR_WIDTH;
   // First wait state is the request cycle itself, so the counter starts one lower.
   localparam logic [2:0] CNT_LOAD = (LATENCY == 0) ? 3'd0 : 3'(LATENCY - 1);

   logic [0:0]            r_state;
   logic [2:0]            r_cnt;
   logic [31:0]           r_spo;
   logic                  r_err;
   logic [31:0]           r_mem [DEPTH];

   logic                  w_req;
   logic                  w_rd;
   logic                  w_in_range;
   logic                  w_accept;
   logic                  w_done;
   logic [ADDR_WIDTH-1:0] w_idx;
   logic                  w_unused;

   // Byte lane bits carry no meaning on a word-only bus.
   assign w_unused   = ^a[1:0];

   assign w_req      = rd | we;
   assign w_rd       = rd & ~we;          // write wins when both strobes are up
   assign w_in_range = (a[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]);
   assign w_idx      = a[ADDR_WIDTH+1:2];
   assign w_accept   = w_req && (r_state == ST_IDLE);
   assign w_done     = (r_state == ST_BUSY) && (r_cnt == 3'd0);

   assign ready = (r_state == ST_IDLE) ? ((LATENCY == 0) || !w_req) : w_done;
   assign err   = r_err;

   generate
      if (LATENCY == 0) begin : g_async
         // Zero wait states: the array is read combinationally in the request cycle.
         logic [31:0] w_rdata;
         assign w_rdata = w_in_range ? r_mem[w_idx] : 32'hffffffff;
         assign spo     = w_rd ? w_rdata : r_spo;
      end else begin : g_sync
         logic [31:0] r_cap;
         logic        r_is_rd;

         // Registered array read at acceptance; out-of-window reads return all ones.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_cap   <= 32'h0;
               r_is_rd <= 1'b0;
            end else if (w_accept) begin
               r_cap   <= w_in_range ? r_mem[w_idx] : 32'hffffffff;
               r_is_rd <= w_rd;
            end
         end

         assign spo = (w_done && r_is_rd) ? r_cap : r_spo;
      end
   endgenerate

   // Sequencer: IDLE accepts a request and loads the wait counter, BUSY counts down to completion.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= 3'd0;
      end else if (r_state == ST_IDLE) begin
         if (w_req && (LATENCY != 0)) begin
            r_state <= ST_BUSY;
            r_cnt   <= CNT_LOAD;
         end
      end else begin
         if (r_cnt != 3'd0) begin
            r_cnt <= r_cnt - 3'd1;
         end else begin
            r_state <= ST_IDLE;
         end
      end
   end

   // spo is a pass-through of r_spo except when a read completes, so tracking it keeps the last read value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_spo <= 32'h0;
      end else begin
         r_spo <= spo;
      end
   end

   // Sticky error: request while busy, both strobes at once, or address outside the window.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_req && ((r_state == ST_BUSY) || (rd && we) || !w_in_range)) begin
         r_err <= 1'b1;
      end
   end

   // Array write on acceptance only; no reset so contents survive rst.
   always_ff @(posedge clk) begin
      if (!rst && w_accept && we && w_in_range) begin
         r_mem[w_idx] <= d;
      end
   end

endmodule

// File: tb/tb_bus_ram_responder.sv
// Purpose: checks bus_ram_responder at LATENCY 0..3 against a word-array reference model.
// Latency: each transaction is followed cycle by cycle until ready returns.
// Backpressure: requests are only issued when the model says the target is idle, except the deliberate busy-collision step.
module tb_bus_ram_responder;

   logic        clk;
   logic        rst_v   [4];
   logic [31:0] a_v     [4];
   logic [31:0] d_v     [4];
   logic        we_v    [4];
   logic        rd_v    [4];
   logic [31:0] spo_v   [4];
   logic        ready_v [4];
   logic        err_v   [4];

   int total = 0;
   int bad   = 0;

   // Reference model: one word array per instance, plus sticky error and last read value.
   logic [31:0] m_mem [4][4096];
   bit          m_vld [4][4096];
   logic        m_err [4];
   logic [31:0] m_spo [4];

   for (genvar g = 0; g < 4; g++) begin : g_dut
      bus_ram_responder #(
         .ADDR_WIDTH (12),
         .BASE_ADDR  (32'hf0000000),
         .LATENCY    (g)
      ) u_dut (
         .clk   (clk),
         .rst   (rst_v[g]),
         .a     (a_v[g]),
         .d     (d_v[g]),
         .we    (we_v[g]),
         .rd    (rd_v[g]),
         .spo   (spo_v[g]),
         .ready (ready_v[g]),
         .err   (err_v[g])
      );
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic bit in_win(input logic [31:0] addr);
      return addr[31:14] == 18'h3c000;
   endfunction

   task automatic check(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s lat=%0d observed=%h expected=%h", tag, k, obs, exp);
      end
   endtask

   task automatic do_reset();
      for (int k = 0; k < 4; k++) begin
         rst_v[k] = 1'b1; we_v[k] = 1'b0; rd_v[k] = 1'b0;
         a_v[k] = 32'h0; d_v[k] = 32'h0;
      end
      @(posedge clk); @(posedge clk); #1;
      for (int k = 0; k < 4; k++) begin
         rst_v[k] = 1'b0; m_err[k] = 1'b0; m_spo[k] = 32'h0;
      end
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         check("rst_ready", k, ready_v[k], 1);
         check("rst_spo",   k, spo_v[k],   32'h0);
         check("rst_err",   k, err_v[k],   0);
      end
      @(posedge clk); #1;
   endtask

   task automatic idle_check(input int k);
      @(negedge clk);
      check("idle_ready", k, ready_v[k], 1);
      check("idle_spo",   k, spo_v[k],   m_spo[k]);
      @(posedge clk); #1;
   endtask

   // One complete transaction on instance k (its LATENCY equals k); entered and left just after a rising edge.
   task automatic txn(input int k, input bit wr, input bit both, input logic [31:0] addr, input logic [31:0] data);
      logic [31:0] exp;
      exp = in_win(addr) ? m_mem[k][addr[13:2]] : 32'hffffffff;
      a_v[k] = addr; d_v[k] = data; we_v[k] = wr; rd_v[k] = !wr || both;
      @(negedge clk);
      if (k == 0) begin
         check("req_ready0", k, ready_v[k], 1);
         check("req_spo0",   k, spo_v[k], wr ? m_spo[k] : exp);
      end else begin
         check("req_ready", k, ready_v[k], 0);
      end
      @(posedge clk); #1;
      we_v[k] = 1'b0; rd_v[k] = 1'b0;
      if (wr) begin
         if (in_win(addr)) begin
            m_mem[k][addr[13:2]] = data;
            m_vld[k][addr[13:2]] = 1'b1;
         end
         if (!in_win(addr) || both) m_err[k] = 1'b1;
      end else begin
         m_spo[k] = exp;
         if (!in_win(addr)) m_err[k] = 1'b1;
      end
      for (int c = 1; c <= k; c++) begin
         @(negedge clk);
         if (c < k) begin
            check("wait_ready", k, ready_v[k], 0);
         end else begin
            check("done_ready", k, ready_v[k], 1);
            check("done_spo",   k, spo_v[k],   m_spo[k]);
         end
         @(posedge clk); #1;
      end
      check("err", k, err_v[k], m_err[k]);
   endtask

   initial begin
      logic [31:0] addr;
      logic [11:0] idx;
      int          r;

      do_reset();

      // LATENCY 2: write then read back, ready low for two cycles each
      txn(2, 1, 0, 32'hf0000010, 32'hdeadbeef);
      txn(2, 0, 0, 32'hf0000010, 32'h0);
      // both strobes: treated as write, flags err
      txn(2, 1, 1, 32'hf0000020, 32'h000055aa);
      txn(2, 0, 0, 32'hf0000020, 32'h0);

      // LATENCY 0: same-cycle response
      txn(0, 1, 0, 32'hf0000000, 32'h00000013);
      txn(0, 0, 0, 32'hf0000000, 32'h0);
      idle_check(0);

      // LATENCY 1: out-of-window read, err stays set afterwards
      txn(1, 0, 0, 32'h10000000, 32'h0);
      idle_check(1);
      // window edges and aliasing
      txn(1, 1, 0, 32'hf0003ffc, 32'h00000001);
      txn(1, 1, 0, 32'hf0000000, 32'h00000002);
      txn(1, 1, 0, 32'hf0004000, 32'h00000099);
      txn(1, 0, 0, 32'hf0003ffc, 32'h0);
      txn(1, 0, 0, 32'hf0000000, 32'h0);
      txn(1, 0, 0, 32'hf0004000, 32'h0);

      // LATENCY 3: write collision during an outstanding read is ignored
      txn(3, 1, 0, 32'hf0000040, 32'hcafef00d);
      a_v[3] = 32'hf0000040; rd_v[3] = 1'b1;
      @(negedge clk); check("col_t0_ready", 3, ready_v[3], 0);
      @(posedge clk); #1;
      rd_v[3] = 1'b0; we_v[3] = 1'b1; d_v[3] = 32'h12345678;
      @(negedge clk); check("col_t1_ready", 3, ready_v[3], 0);
      @(posedge clk); #1;
      we_v[3] = 1'b0; m_err[3] = 1'b1; m_spo[3] = 32'hcafef00d;
      @(negedge clk); check("col_t2_ready", 3, ready_v[3], 0);
      @(posedge clk); #1;
      @(negedge clk);
      check("col_t3_ready", 3, ready_v[3], 1);
      check("col_t3_spo",   3, spo_v[3],   32'hcafef00d);
      check("col_t3_err",   3, err_v[3],   1);
      @(posedge clk); #1;
      txn(3, 0, 0, 32'hf0000040, 32'h0);

      // LATENCY 3: reset during BUSY aborts, committed write survives
      a_v[3] = 32'hf0000080; d_v[3] = 32'haaaa5555; we_v[3] = 1'b1;
      @(negedge clk); check("rb_t0_ready", 3, ready_v[3], 0);
      @(posedge clk); #1;
      we_v[3] = 1'b0; rst_v[3] = 1'b1;
      m_mem[3][12'h020] = 32'haaaa5555; m_vld[3][12'h020] = 1'b1;
      @(posedge clk); #1;
      rst_v[3] = 1'b0; m_err[3] = 1'b0; m_spo[3] = 32'h0;
      @(negedge clk);
      check("rb_t2_ready", 3, ready_v[3], 1);
      check("rb_t2_spo",   3, spo_v[3],   32'h0);
      check("rb_t2_err",   3, err_v[3],   0);
      @(posedge clk); #1;
      txn(3, 0, 0, 32'hf0000080, 32'h0);

      // Randomized traffic on every latency
      do_reset();
      for (int k = 0; k < 4; k++) begin
         for (int n = 0; n < 40; n++) begin
            r   = int'($urandom_range(0, 9));
            idx = 12'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) idx = idx | 12'hff8;
            addr = {18'h3c000, idx, 2'($urandom_range(0, 3))};
            if (r < 4 || !m_vld[k][idx]) begin
               txn(k, 1, 0, addr, $urandom);
            end else if (r < 8) begin
               txn(k, 0, 0, addr, 32'h0);
            end else if (r == 8) begin
               addr = $urandom;
               if (in_win(addr)) addr[31] = 1'b0;
               if ($urandom_range(0, 1) == 1) txn(k, 1, 0, addr, $urandom);
               else                           txn(k, 0, 0, addr, 32'h0);
            end else begin
               idle_check(k);
            end
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/bus_ram_responder.md
# bus_ram_responder

Word-addressed RAM responder on the pCPU memory bus, the target end of the `a`/`d`/`we`/`rd`/`spo`/`ready` interface driven by the multicycle RISC-V core. It decodes one aligned address window, services single-word reads and writes after a programmable number of wait states, and holds `ready` low while a transaction is outstanding. It sits behind the bus interconnect as the boot/main RAM and is the default memory model for core-level simulation.

## Interface
- `ADDR_WIDTH`, 12: word-address bits; capacity 2^ADDR_WIDTH words (16 KiB at default).
- `BASE_ADDR`, 32'hf0000000: window base; must be aligned to 2^(ADDR_WIDTH+2) bytes.
- `LATENCY`, 1: wait states, 0..7; 0 gives same-cycle combinational response.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `a`  in  32  byte address; `a[1:0]` ignored.
- `d`  in  32  write data, stored verbatim (no byte swapping in this block).
- `we`  in  1  write request strobe, one cycle per transaction.
- `rd`  in  1  read request strobe, one cycle per transaction.
- `spo`  out  32  read data; valid in the cycle `ready`=1 that completes a read.
- `ready`  out  1  high when idle or completing; low while a transaction is outstanding.
- `err`  out  1  sticky error flag; cleared only by `rst`.

## Operation
- Request = `rd|we` sampled high. `we` has priority if both high (treated as write, `err` set).
- In-range: `a[31:ADDR_WIDTH+2] == BASE_ADDR[31:ADDR_WIDTH+2]`; index = `a[ADDR_WIDTH+1:2]`.
- States: IDLE, BUSY. `cnt` is 3-bit down-counter.
- IDLE, no request: `ready`=1, `spo` holds last read value.
- IDLE, request, LATENCY=0: read drives `spo`=mem[index] combinationally, `ready`=1; write commits at cycle-end edge; stay IDLE.
- IDLE, request, LATENCY≥1: `ready`=0 combinationally in request cycle. At cycle-end edge: write commits `d` to mem[index]; read captures mem[index] into data register; `cnt`←LATENCY-1; go BUSY.
- BUSY, `cnt`≠0: `ready`=0, `cnt`←`cnt`-1.
- BUSY, `cnt`=0: `ready`=1, `spo`=captured data (reads; writes leave `spo` unchanged); go IDLE next edge.
- Request sampled in BUSY: ignored (no write, no capture), `err`←1; current transaction completes unchanged.
- Out-of-range: normal handshake timing; write discarded; read returns 32'hffffffff; `err`←1.
- Memory array not cleared by reset; contents persist across `rst`.

## Timing
- Reset values: `ready`=1, `spo`=0, `err`=0, state IDLE, `cnt`=0.
- Request at cycle T0: `ready` high first in T0+LATENCY; next request accepted from T0+LATENCY+1 (LATENCY≥1) or T0+1 (LATENCY=0).
- Write visible to a read issued in any later cycle (read-after-write has no hazard).
- Read array synchronous for LATENCY≥1 (BRAM-inferable); asynchronous only when LATENCY=0.
- `rst` high at an edge overrides everything: no write commit, no capture, BUSY aborted to IDLE; `ready`=1 in the following cycle.
- `err` update occurs at the same edge as the offending request is sampled.

## Test plan
- LATENCY=2: write 32'hdeadbeef to 32'hf0000010 at T0 -> `ready`=0 T0..T1, 1 at T2; read same address at T3 -> `ready`=1 at T5 with `spo`=32'hdeadbeef, `err`=0.
- LATENCY=0: read 32'hf0000000 after writing 32'h00000013 -> `ready`=1 and `spo`=32'h00000013 in the request cycle.
- Read 32'h10000000 (out of window), LATENCY=1 -> `ready`=1 one cycle later, `spo`=32'hffffffff, `err`=1; it stays 1 until `rst`.
- LATENCY=3: read at T0, extra `we` pulse to same address with 32'h12345678 at T1 -> ignored, `err`=1, `spo` returns original data at T3, memory unchanged.
- LATENCY=3: write 32'haaaa5555 at T0, `rst` at T1 -> `ready`=1 at T2, `spo`=0; subsequent read returns 32'haaaa5555 (committed before reset).
- Address wrap: write 32'h1 to 32'hf0003ffc and 32'h2 to 32'hf0000000 -> both read back independently; 32'hf0004000 flagged out-of-range.
